g3_logic: RTL and testbench
===========================

Name: g3_logic

Overview:
- Six-input, two-output combinational logic core: sum-of-products and product-of-sums of three input pairs.
- Wrapped in input synchronisers and an output register so the block can sit directly behind asynchronous switch/pin inputs.
- Both outputs are registered.
- Used as a small glue-logic leaf under the board top level.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each input synchroniser; legal range 1..4.
- DEBOUNCE_CYCLES, 4, consecutive cycles a changed input must stay stable before it is accepted; only used when G3_DEBOUNCE_EN is defined; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  data input, pair 1 bit 0 (asynchronous to clk).
- b  input  1  data input, pair 1 bit 1.
- c  input  1  data input, pair 2 bit 0.
- d  input  1  data input, pair 2 bit 1.
- e  input  1  data input, pair 3 bit 0.
- f  input  1  data input, pair 3 bit 1.
- z1  output  1  registered SOP result.
- z2  output  1  registered POS result.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - rst_n low immediately clears all synchroniser flops, debounce state and both output registers.
  - z1=0 and z2=0 while rst_n is low.
  - Release of rst_n is taken on the next clk rising edge; no further clearing occurs after release.
- Synchronisers: each of a..f passes through its own SYNC_STAGES-deep flop chain. The synchronised bits are named sa..sf.
- Logic functions, computed on the synchronised (or filtered) bits:
  - z1 = (sa AND sb) OR (sc AND sd) OR (se AND sf).
  - z2 = (sa OR sb) AND (sc OR sd) AND (se OR sf).
- Output register: z1 and z2 are each registered once; no combinational path from any input to any output.
- Latency (G3_DEBOUNCE_EN undefined):
  - An input held stable before rising edge k is reflected on z1/z2 after edge k+SYNC_STAGES.
  - This is SYNC_STAGES+1 edges; 3 edges at the default setting.
- Throughput and timing:
  - A new input pattern may be applied every cycle; outputs track it in order with fixed latency.
  - There is no valid/handshake signal; the outputs are always meaningful after reset.
- Simultaneous changes:
  - All six bits are processed independently and in parallel.
  - Because of synchroniser skew, transient output values may appear for one cycle when several bits change at once.
  - Transient outputs are acceptable; the final value must equal the function of the final input pattern.
- Reset mid-operation: pipeline contents are discarded and outputs return to 0 asynchronously; no stale value is produced after release.

Optional Feature:
- Macro: G3_DEBOUNCE_EN.
- Defined:
  - A per-bit debounce filter sits between each synchroniser and the logic core.
  - Each bit has a filtered value and a counter (width ceil(log2(DEBOUNCE_CYCLES+1))).
  - When the synchronised bit differs from the filtered value, the counter increments each cycle.
  - When it differs for DEBOUNCE_CYCLES consecutive cycles, the filtered value takes the new value and the counter clears.
  - Any cycle where the two are equal clears the counter.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are rejected.
  - Latency grows by exactly DEBOUNCE_CYCLES edges.
  - Reset clears filtered values and counters to 0.
- Undefined: no filter, no counters; synchronised bits feed the logic core directly.

Test Plan:
- Assert rst_n=0 with abcdef=111111 -> z1=0, z2=0 throughout reset. Release, hold 111111 -> z1=1, z2=1 after 3 edges.
- abcdef=000000 for 5 cycles -> z1=0, z2=0.
- abcdef=010101 -> z1=0, z2=1 after 3 edges.
- abcdef=101010 -> z1=0, z2=1. Then abcdef=110000 -> z1=1, z2=0. Then abcdef=001100 -> z1=1, z2=0.
- Hold 111111 (z1=1,z2=1), then pull rst_n low mid-cycle -> both outputs go 0 before the next clk edge. After release they return to 1 after 3 edges.
- With G3_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, starting from 000000:
  - Set abcdef=110000 for 2 cycles, then back to 000000 -> z1 stays 0.
  - Set 110000 and hold -> z1=1 after 7 edges.

Source files
------------

// File: rtl/g3_logic.sv
// rtl/g3_logic.sv - synchronised, registered SOP/POS glue-logic core
//
// Six asynchronous pin inputs are each passed through a SYNC_STAGES-deep
// synchroniser, optionally debounced, then combined into a sum-of-products
// (z1) and product-of-sums (z2) of the pairs (a,b), (c,d), (e,f). Both
// results are registered, so there is no combinational input-to-output path.
//
// Optional feature macro: G3_DEBOUNCE_EN (per-bit debounce filter between
// each synchroniser and the logic core; adds DEBOUNCE_CYCLES edges latency).
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   a..f   in   data inputs, asynchronous to clk (pairs ab, cd, ef)
//   z1     out  registered (sa&sb) | (sc&sd) | (se&sf)
//   z2     out  registered (sa|sb) & (sc|sd) & (se|sf)

module g3_logic #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  output logic z1,
  output logic z2
);

  // Elaboration-time legality checks on the parameters.
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("g3_logic: SYNC_STAGES must be in 1..4");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("g3_logic: DEBOUNCE_CYCLES must be in 1..255");
  end

  // Bit 5 = a ... bit 0 = f, so each pair occupies an aligned 2-bit slice.
  logic [5:0] raw_bits;
  logic [5:0] sync_bits;
  logic [5:0] core_bits;

  assign raw_bits = {a, b, c, d, e, f};

  // Per-bit synchroniser chains; all six bits share one stage index so each
  // bit has its own independent flop chain of SYNC_STAGES flops.
  logic [5:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw_bits;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_bits = sync_q[SYNC_STAGES-1];

`ifdef G3_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [5:0]       filt_q;
  logic [CNT_W-1:0] cnt_q [6];

  // The counter holds how many consecutive cycles the synchronised bit has
  // disagreed with the filtered value so far; the DEBOUNCE_CYCLES-th
  // disagreeing cycle commits the new value, giving exactly DEBOUNCE_CYCLES
  // edges of added latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync_bits[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync_bits[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign core_bits = filt_q;
`else
  assign core_bits = sync_bits;
`endif

  logic sa, sb, sc, sd, se, sf;
  logic z1_d, z2_d;

  assign {sa, sb, sc, sd, se, sf} = core_bits;

  assign z1_d = (sa & sb) | (sc & sd) | (se & sf);
  assign z2_d = (sa | sb) & (sc | sd) & (se | sf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z1 <= 1'b0;
      z2 <= 1'b0;
    end else begin
      z1 <= z1_d;
      z2 <= z2_d;
    end
  end

endmodule

// File: tb/tb_g3_logic.sv
// tb/tb_g3_logic.sv - self-checking bench for g3_logic

module tb_g3_logic;

`ifdef G3_DEBOUNCE_EN
  localparam int LAT      = 7;
  localparam int HOLD_MIN = 4;
  localparam int HOLD_MAX = 6;
`else
  localparam int LAT      = 3;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0, f = 1'b0;
  logic z1, z2;

  int n_checks = 0;
  int n_errors = 0;

  // Patterns that will reach the output register, oldest first; a slot
  // holds 000000 when that capture happens under reset.
  logic [5:0] pipe [$];

  g3_logic #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .e    (e),
    .f    (f),
    .z1   (z1),
    .z2   (z2)
  );

  always #5 clk = ~clk;

  // Returns {z1, z2} for pattern abcdef (bit 5 = a).
  function automatic logic [1:0] ref_fn(input logic [5:0] p);
    logic       any_pair;
    logic       all_pairs;
    logic [1:0] pr;
    any_pair  = 1'b0;
    all_pairs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pr        = p[2*k+1 -: 2];
      any_pair  = any_pair | (&pr);
      all_pairs = all_pairs & (|pr);
    end
    return {any_pair, all_pairs};
  endfunction

  task automatic chk(input string tag, input logic [1:0] exp);
    n_checks++;
    assert ({z1, z2} === exp) else begin
      n_errors++;
      $error("FAIL %s: observed z1z2=%b expected z1z2=%b", tag, {z1, z2}, exp);
    end
  endtask

  task automatic clear_pipe(input logic [5:0] v);
    pipe.delete();
    repeat (LAT) pipe.push_back(v);
  endtask

  // One clock cycle: at the falling edge, check against the model, then
  // apply the next reset level and pattern for the coming rising edge.
  task automatic cycle(input string tag, input logic [5:0] p, input logic r);
    @(negedge clk);
    chk(tag, ref_fn(pipe[0]));
    rst_n = r;
    {a, b, c, d, e, f} = p;
    pipe.push_back(r ? p : 6'b000000);
    pipe.delete(0);
  endtask

  task automatic hold(input string tag, input logic [5:0] p, input int n);
    repeat (n) cycle(tag, p, 1'b1);
  endtask

`ifdef G3_DEBOUNCE_EN
  // Drives without the delay model; checks a fixed expected output.
  task automatic raw_cycle(input string tag, input logic [5:0] p, input logic [1:0] exp);
    @(negedge clk);
    chk(tag, exp);
    {a, b, c, d, e, f} = p;
  endtask
`endif

  initial begin
    logic [5:0] rp;
    int         hl;

    clear_pipe(6'b000000);
    {a, b, c, d, e, f} = 6'b111111;
    rst_n = 1'b0;

    repeat (4) cycle("reset_hold", 6'b111111, 1'b0);
    chk("reset_z_const", 2'b00);

    hold("release_111111", 6'b111111, LAT + 1);
    chk("hold_111111_const", 2'b11);

    hold("zeros", 6'b000000, LAT + 2);
    chk("zeros_const", 2'b00);

    hold("p010101", 6'b010101, LAT + 1);
    chk("p010101_const", 2'b01);

    hold("p101010", 6'b101010, LAT + 1);
    chk("p101010_const", 2'b01);

    hold("p110000", 6'b110000, LAT + 1);
    chk("p110000_const", 2'b10);

    hold("p001100", 6'b001100, LAT + 1);
    chk("p001100_const", 2'b10);

`ifdef G3_DEBOUNCE_EN
    hold("db_pre_zero", 6'b000000, LAT + 1);
    chk("db_pre_zero_const", 2'b00);
    raw_cycle("db_pulse", 6'b110000, 2'b00);
    raw_cycle("db_pulse", 6'b110000, 2'b00);
    repeat (10) raw_cycle("db_pulse_rejected", 6'b000000, 2'b00);
    raw_cycle("db_hold_start", 6'b110000, 2'b00);
    repeat (6) raw_cycle("db_hold_wait", 6'b110000, 2'b00);
    raw_cycle("db_hold_edge7", 6'b110000, 2'b10);
    clear_pipe(6'b110000);
    hold("db_hold_steady", 6'b110000, 2);
`endif

    for (int s = 0; s < 40; s++) begin
      rp = 6'($urandom);
      hl = $urandom_range(HOLD_MAX, HOLD_MIN);
      hold("random", rp, hl);
    end

    hold("mid_pre", 6'b111111, LAT + 1);
    chk("mid_pre_const", 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_clear", 2'b00);
    clear_pipe(6'b000000);
    cycle("mid_in_reset", 6'b111111, 1'b0);
    cycle("mid_in_reset", 6'b111111, 1'b0);
    hold("mid_release", 6'b111111, LAT + 1);
    chk("mid_release_const", 2'b11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
